mem_port_arbiter: RTL and testbench

- Shares the single main-memory word port between the instruction-fetch cache controller (IF, read-only) and the memory-access-stage cache controller (MA, read/write).
- Sequences each transfer over a fixed memory latency, returns a one-cycle ready pulse to the winning requester, and uses round-robin fairness on simultaneous requests.
- Sits between both cache controllers and the main-memory model.

---
 rtl/mem_arb_pkg.sv | 19 +
 rtl/rr_arb2.sv | 29 ++
 rtl/mem_port_arbiter.sv | 134 +++++++++++++
 tb/tb_mem_port_arbiter.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared types and constants for the main-memory port arbiter.
//   state_e  : arbiter FSM states (IDLE, ACCESS, DONE)
//   REQ_IF   : requester id of the instruction-fetch cache controller
//   REQ_MA   : requester id of the memory-access-stage cache controller
//   CNT_W    : width of the memory latency counter (MEM_LATENCY <= 15)
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_e;

    localparam logic REQ_IF = 1'b0;
    localparam logic REQ_MA = 1'b1;

    localparam int CNT_W = 4;

endpackage

// File: rtl/rr_arb2.sv
// rr_arb2: two-input round-robin grant with a last-grant register.
//   clk      : system clock, rising edge
//   rst_n    : asynchronous active-low reset (last grant -> REQ_IF)
//   req_i    : request vector, bit REQ_IF / bit REQ_MA
//   accept_i : strobe, the current grant is taken and becomes the last grant
//   gnt_o    : id of the winning requester (valid when any req_i bit is set)
module rr_arb2 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req_i,
    input  logic       accept_i,
    output logic       gnt_o
);
    import mem_arb_pkg::*;

    logic last_q, last_d;

    // A tie goes to whoever was not served last; a lone request wins outright.
    always_comb begin
        gnt_o  = (req_i[REQ_IF] && req_i[REQ_MA]) ? ~last_q : req_i[REQ_MA];
        last_d = accept_i ? gnt_o : last_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) last_q <= REQ_IF;
        else        last_q <= last_d;
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares the main-memory word port between the IF (read-only)
// and MA (read/write) cache controllers with round-robin fairness.
//   clk, rst_n                 : clock, asynchronous active-low reset
//   if_req_i / if_addr_i       : IF read request and word address
//   if_ready_o / if_rdata_o    : IF completion pulse and held read data
//   ma_req_i, ma_we_i          : MA request and write select
//   ma_addr_i, ma_wdata_i      : MA address and write data
//   ma_ready_o / ma_rdata_o    : MA completion pulse and held read data
//   mem_addr_o, mem_we_o       : memory address and write strobe
//   mem_wdata_o, mem_rdata_i   : memory write data and read data
//   busy_o                     : transfer in progress (ACCESS or DONE)
//   grant_ma_o                 : current or last owner (1 = MA, 0 = IF)
module mem_port_arbiter #(
    parameter int MEM_LATENCY = 4,
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              if_req_i,
    input  logic [ADDR_W-1:0] if_addr_i,
    output logic              if_ready_o,
    output logic [DATA_W-1:0] if_rdata_o,
    input  logic              ma_req_i,
    input  logic              ma_we_i,
    input  logic [ADDR_W-1:0] ma_addr_i,
    input  logic [DATA_W-1:0] ma_wdata_i,
    output logic              ma_ready_o,
    output logic [DATA_W-1:0] ma_rdata_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic              mem_we_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    input  logic [DATA_W-1:0] mem_rdata_i,
    output logic              busy_o,
    output logic              grant_ma_o
);
    import mem_arb_pkg::*;

    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MEM_LATENCY - 1);

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
    logic [DATA_W-1:0] ma_rdata_q, ma_rdata_d;
    logic              we_q, we_d;
    logic              owner_q, owner_d;
    logic              gnt;
    logic              accept;
    logic              last_cyc;

    // Requests only count while the port is free.
    assign accept   = (state_q == IDLE) && (if_req_i || ma_req_i);
    assign last_cyc = (state_q == ACCESS) && (cnt_q == '0);

    rr_arb2 u_rr (
        .clk      (clk),
        .rst_n    (rst_n),
        .req_i    ({ma_req_i, if_req_i}),
        .accept_i (accept),
        .gnt_o    (gnt)
    );

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        we_d       = we_q;
        owner_d    = owner_q;
        if_rdata_d = if_rdata_q;
        ma_rdata_d = ma_rdata_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = ACCESS;
                    owner_d = gnt;
                    addr_d  = (gnt == REQ_MA) ? ma_addr_i : if_addr_i;
                    // IF is read-only, so its transfers never write.
                    we_d    = (gnt == REQ_MA) && ma_we_i;
                    wdata_d = ma_wdata_i;
                    cnt_d   = CNT_LOAD;
                end
            end
            ACCESS: begin
                if (last_cyc) begin
                    state_d = DONE;
                    // Memory data is valid only in the last ACCESS cycle.
                    if (!we_q && owner_q == REQ_MA) ma_rdata_d = mem_rdata_i;
                    if (!we_q && owner_q == REQ_IF) if_rdata_d = mem_rdata_i;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
            we_q       <= 1'b0;
            owner_q    <= REQ_IF;
            if_rdata_q <= '0;
            ma_rdata_q <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            we_q       <= we_d;
            owner_q    <= owner_d;
            if_rdata_q <= if_rdata_d;
            ma_rdata_q <= ma_rdata_d;
        end
    end

    // The write strobe is a single pulse at the end of the access window.
    assign mem_we_o    = last_cyc && we_q;
    assign mem_addr_o  = addr_q;
    assign mem_wdata_o = wdata_q;
    assign busy_o      = (state_q != IDLE);
    assign grant_ma_o  = owner_q;
    assign if_ready_o  = (state_q == DONE) && (owner_q == REQ_IF);
    assign ma_ready_o  = (state_q == DONE) && (owner_q == REQ_MA);
    assign if_rdata_o  = if_rdata_q;
    assign ma_rdata_o  = ma_rdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: checks two arbiter instances (MEM_LATENCY 4 and 1)
// against a transaction-level model plus directed literal expectations.
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [1:0]  if_req, ma_req, ma_we;
    logic [1:0]  if_ready, ma_ready, mem_we, busy, grant_ma;
    logic [31:0] if_addr [2];
    logic [31:0] ma_addr [2];
    logic [31:0] ma_wdata [2];
    logic [31:0] if_rdata [2];
    logic [31:0] ma_rdata [2];
    logic [31:0] mem_addr [2];
    logic [31:0] mem_wdata [2];
    logic [31:0] mem_rdata [2];

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    function automatic logic [31:0] rd_fn(input logic [31:0] a);
        return (a == 32'h40) ? 32'hDEADBEEF : (a ^ 32'h5A5A0F0F);
    endfunction

    function automatic int lat(input int i);
        return (i == 0) ? 4 : 1;
    endfunction

    assign mem_rdata[0] = rd_fn(mem_addr[0]);
    assign mem_rdata[1] = rd_fn(mem_addr[1]);

    mem_port_arbiter #(.MEM_LATENCY(4), .ADDR_W(32), .DATA_W(32)) u0 (
        .clk(clk), .rst_n(rst_n),
        .if_req_i(if_req[0]), .if_addr_i(if_addr[0]),
        .if_ready_o(if_ready[0]), .if_rdata_o(if_rdata[0]),
        .ma_req_i(ma_req[0]), .ma_we_i(ma_we[0]), .ma_addr_i(ma_addr[0]),
        .ma_wdata_i(ma_wdata[0]), .ma_ready_o(ma_ready[0]), .ma_rdata_o(ma_rdata[0]),
        .mem_addr_o(mem_addr[0]), .mem_we_o(mem_we[0]), .mem_wdata_o(mem_wdata[0]),
        .mem_rdata_i(mem_rdata[0]), .busy_o(busy[0]), .grant_ma_o(grant_ma[0])
    );

    mem_port_arbiter #(.MEM_LATENCY(1), .ADDR_W(32), .DATA_W(32)) u1 (
        .clk(clk), .rst_n(rst_n),
        .if_req_i(if_req[1]), .if_addr_i(if_addr[1]),
        .if_ready_o(if_ready[1]), .if_rdata_o(if_rdata[1]),
        .ma_req_i(ma_req[1]), .ma_we_i(ma_we[1]), .ma_addr_i(ma_addr[1]),
        .ma_wdata_i(ma_wdata[1]), .ma_ready_o(ma_ready[1]), .ma_rdata_o(ma_rdata[1]),
        .mem_addr_o(mem_addr[1]), .mem_we_o(mem_we[1]), .mem_wdata_o(mem_wdata[1]),
        .mem_rdata_i(mem_rdata[1]), .busy_o(busy[1]), .grant_ma_o(grant_ma[1])
    );

    task automatic chk(input string nm, input int i, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s inst%0d got=%h expected=%h", nm, i, got, exp);
        end
    endtask

    // Transaction model: a granted transfer has an age counted from 1 in the
    // first cycle after the grant; ages 1..L are the access window, L+1 is the
    // completion cycle.
    bit          m_act [2];
    int          m_age [2];
    logic        m_own [2];
    logic        m_last [2];
    logic        m_we [2];
    logic [31:0] m_addr [2];
    logic [31:0] m_wd [2];
    logic [31:0] m_ifr [2];
    logic [31:0] m_mar [2];

    initial forever begin
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            int   l;
            logic fin, done, w;
            l = lat(i);
            if (!rst_n) begin
                m_act[i] = 0; m_age[i] = 0; m_own[i] = 0; m_last[i] = 0; m_we[i] = 0;
                m_addr[i] = 0; m_wd[i] = 0; m_ifr[i] = 0; m_mar[i] = 0;
            end
            fin  = m_act[i] && (m_age[i] == l);
            done = m_act[i] && (m_age[i] == l + 1);
            chk("busy", i, busy[i], m_act[i]);
            chk("grant_ma", i, grant_ma[i], m_own[i]);
            chk("mem_we", i, mem_we[i], fin && m_we[i]);
            chk("mem_addr", i, mem_addr[i], m_addr[i]);
            chk("mem_wdata", i, mem_wdata[i], m_wd[i]);
            chk("if_ready", i, if_ready[i], done && !m_own[i]);
            chk("ma_ready", i, ma_ready[i], done && m_own[i]);
            chk("if_rdata", i, if_rdata[i], m_ifr[i]);
            chk("ma_rdata", i, ma_rdata[i], m_mar[i]);
            if (rst_n) begin
                if (m_act[i]) begin
                    if (done) m_act[i] = 0;
                    else begin
                        if (fin && !m_we[i]) begin
                            if (m_own[i]) m_mar[i] = rd_fn(m_addr[i]);
                            else          m_ifr[i] = rd_fn(m_addr[i]);
                        end
                        m_age[i]++;
                    end
                end else if (if_req[i] || ma_req[i]) begin
                    w = (if_req[i] && ma_req[i]) ? !m_last[i] : ma_req[i];
                    m_own[i]  = w;
                    m_last[i] = w;
                    m_addr[i] = w ? ma_addr[i] : if_addr[i];
                    m_we[i]   = w && ma_we[i];
                    m_wd[i]   = ma_wdata[i];
                    m_act[i]  = 1;
                    m_age[i]  = 1;
                end
            end
        end
    end

    int   rq_cyc [$];
    int   rq_who [$];
    int   we_cyc, we_n, acc_n;
    logic [31:0] we_dat;
    logic gh [128];
    logic bh [128];

    // Issue requests on instance i; each requester holds its request until it
    // has seen its quota of completions. k is the cycle number, 0 = first
    // cycle the request is visible.
    task automatic run(input int i, input int q_if, input int q_ma, input logic we,
                       input logic [31:0] ia, input logic [31:0] ma, input logic [31:0] wd);
        int n_if = 0;
        int n_ma = 0;
        rq_cyc.delete(); rq_who.delete();
        we_cyc = -1; we_n = 0; acc_n = 0; we_dat = 0;
        @(posedge clk); #1;
        if_req[i] = (q_if > 0); if_addr[i] = ia;
        ma_req[i] = (q_ma > 0); ma_we[i] = we; ma_addr[i] = ma; ma_wdata[i] = wd;
        for (int k = 0; k < 100 && (n_if < q_if || n_ma < q_ma); k++) begin
            @(negedge clk);
            gh[k] = grant_ma[i];
            bh[k] = busy[i];
            if (busy[i] && !if_ready[i] && !ma_ready[i]) acc_n++;
            if (mem_we[i]) begin we_cyc = k; we_n++; we_dat = mem_wdata[i]; end
            if (if_ready[i]) begin n_if++; rq_cyc.push_back(k); rq_who.push_back(0); end
            if (ma_ready[i]) begin n_ma++; rq_cyc.push_back(k); rq_who.push_back(1); end
            @(posedge clk); #1;
            if (n_if >= q_if) if_req[i] = 0;
            if (n_ma >= q_ma) ma_req[i] = 0;
        end
        if (n_if < q_if || n_ma < q_ma) chk("timeout", i, n_if + n_ma, q_if + q_ma);
        if_req[i] = 0; ma_req[i] = 0;
    endtask

    task automatic do_reset();
        @(posedge clk); #1; rst_n = 0;
        @(posedge clk); #1; rst_n = 1;
    endtask

    initial begin
        int wn, rn;
        if_req = 0; ma_req = 0; ma_we = 0;
        for (int i = 0; i < 2; i++) begin
            if_addr[i] = 0; ma_addr[i] = 0; ma_wdata[i] = 0;
        end
        repeat (2) @(posedge clk);
        #1 rst_n = 1;
        @(negedge clk);
        chk("rst_busy", 0, busy[0], 0);
        chk("rst_grant", 0, grant_ma[0], 0);
        chk("rst_addr", 0, mem_addr[0], 0);
        chk("rst_ready", 0, if_ready[0], 0);

        // IF read, latency 4
        run(0, 1, 0, 0, 32'h40, 32'h0, 32'h0);
        chk("t1_nready", 0, rq_cyc.size(), 1);
        chk("t1_cycle", 0, rq_cyc[0], 5);
        chk("t1_who", 0, rq_who[0], 0);
        chk("t1_rdata", 0, if_rdata[0], 32'hDEADBEEF);
        chk("t1_we_n", 0, we_n, 0);
        chk("t1_access", 0, acc_n, 4);

        // MA write
        run(0, 0, 1, 1, 32'h0, 32'h100, 32'h11223344);
        chk("t2_cycle", 0, rq_cyc[0], 5);
        chk("t2_who", 0, rq_who[0], 1);
        chk("t2_we_cyc", 0, we_cyc, 4);
        chk("t2_we_n", 0, we_n, 1);
        chk("t2_wdata", 0, we_dat, 32'h11223344);
        chk("t2_ma_rdata", 0, ma_rdata[0], 32'h0);

        // Simultaneous requests right after reset: MA first
        do_reset();
        run(0, 1, 1, 0, 32'h80, 32'h200, 32'h0);
        chk("t3_grant1", 0, gh[1], 1);
        chk("t3_idle6", 0, bh[6], 0);
        chk("t3_grant7", 0, gh[7], 0);
        chk("t3_ma_cyc", 0, rq_cyc[0], 5);
        chk("t3_ma_who", 0, rq_who[0], 1);
        chk("t3_if_cyc", 0, rq_cyc[1], 11);
        chk("t3_if_who", 0, rq_who[1], 0);
        chk("t3_ma_rdata", 0, ma_rdata[0], 32'h5A5A0D0F);
        chk("t3_if_rdata", 0, if_rdata[0], 32'h5A5A0F8F);

        // Both held for four transfers: strict alternation
        run(0, 2, 2, 0, 32'h84, 32'h204, 32'h0);
        chk("t4_n", 0, rq_cyc.size(), 4);
        for (int j = 0; j < 4; j++) begin
            chk("t4_cyc", 0, rq_cyc[j], 5 + 6 * j);
            chk("t4_who", 0, rq_who[j], (j % 2 == 0) ? 1 : 0);
        end

        // Reset in ACCESS cycle 2 of an MA write
        wn = 0; rn = 0;
        @(posedge clk); #1;
        ma_req[0] = 1; ma_we[0] = 1; ma_addr[0] = 32'h120; ma_wdata[0] = 32'hA5A5A5A5;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            wn += mem_we[0]; rn += ma_ready[0];
            @(posedge clk); #1;
        end
        rst_n = 0;
        @(negedge clk);
        chk("t5_busy", 0, busy[0], 0);
        chk("t5_we", 0, mem_we[0], 0);
        @(posedge clk); #1;
        rst_n = 1; ma_req[0] = 0; ma_we[0] = 0;
        repeat (6) begin
            @(negedge clk);
            wn += mem_we[0]; rn += ma_ready[0];
        end
        chk("t5_we_n", 0, wn, 0);
        chk("t5_ready_n", 0, rn, 0);
        run(0, 1, 0, 0, 32'h44, 32'h0, 32'h0);
        chk("t5_if_cyc", 0, rq_cyc[0], 5);
        chk("t5_if_rdata", 0, if_rdata[0], 32'h5A5A0F4B);

        // Latency 1
        run(1, 1, 0, 0, 32'h40, 32'h0, 32'h0);
        chk("t6_if_cyc", 1, rq_cyc[0], 2);
        chk("t6_if_rdata", 1, if_rdata[1], 32'hDEADBEEF);
        chk("t6_access", 1, acc_n, 1);
        run(1, 0, 1, 1, 32'h0, 32'h300, 32'hCAFEF00D);
        chk("t6_we_cyc", 1, we_cyc, 1);
        chk("t6_wdata", 1, we_dat, 32'hCAFEF00D);
        chk("t6_ma_cyc", 1, rq_cyc[0], 2);
        run(1, 0, 1, 0, 32'h0, 32'h40, 32'h0);
        chk("t6_ma_rdata", 1, ma_rdata[1], 32'hDEADBEEF);
        run(1, 2, 0, 0, 32'h48, 32'h0, 32'h0);
        chk("t6_b2b_n", 1, rq_cyc.size(), 2);
        chk("t6_b2b_0", 1, rq_cyc[0], 2);
        chk("t6_b2b_1", 1, rq_cyc[1], 5);
        chk("t6_b2b_rdata", 1, if_rdata[1], 32'h5A5A0F47);

        repeat (2) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
